// File: rtl/param_sched_if.sv
// -----------------------------------------------------------------------------
// param_sched_if
// Bundle between the parameter-fetch sequencer and its neighbours.
// Signal names match the block's documented port list.
//
//   start, abort          : run control from the top-level control FSM
//   base_addr, count      : run range, latched on start
//   en_get_param          : enable to get_param
//   current_finish        : get_param finished the current set
//   position              : get_param execution position, captured on finish
//   item_valid/item_ready : result handshake to the downstream engine
//   item_idx/addr/pos     : result payload
//   busy, done, err       : run status
//
// Modports:
//   master : the sequencer itself (param_sched)
//   slave  : the surrounding control / get_param / downstream side
// -----------------------------------------------------------------------------
interface param_sched_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] count;
    logic              en_get_param;
    logic              current_finish;
    logic [3:0]        position;
    logic              item_valid;
    logic              item_ready;
    logic [ADDR_W-1:0] item_idx;
    logic [ADDR_W-1:0] item_addr;
    logic [3:0]        item_pos;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, abort, base_addr, count, current_finish, position, item_ready,
        output en_get_param, item_valid, item_idx, item_addr, item_pos, busy, done, err
    );

    modport slave (
        output start, abort, base_addr, count, current_finish, position, item_ready,
        input  en_get_param, item_valid, item_idx, item_addr, item_pos, busy, done, err
    );
endinterface

// File: rtl/param_sched.sv
// -----------------------------------------------------------------------------
// param_sched
// Parameter-fetch sequencer. Walks base_addr .. base_addr+count-1, enables
// get_param once per set, waits for current_finish, then offers the captured
// (index, address, position) on a valid/ready handshake.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous, active-high reset
//   ps_if  : param_sched_if.master (see interface file for signal list)
//
// Optional feature macro: PARAM_SCHED_TIMEOUT_EN
//   defined   -> TO_W-bit WAIT watchdog; expiry ends the run with done+err
//   undefined -> WAIT waits indefinitely, err tied low
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no run; start sampled here
// LAUNCH | en_get_param raised; current_finish ignored (may be stale)
// WAIT   | en_get_param held; waiting for current_finish
// HAND   | item_valid held with stable payload until item_ready
// DONE   | one-cycle done pulse, then IDLE
// -----------------------------------------------------------------------------
module param_sched #(
    parameter int ADDR_W = 12,
    parameter int TO_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    param_sched_if.master ps_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HAND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] item_idx_q, item_idx_d;
    logic [ADDR_W-1:0] item_addr_q, item_addr_d;
    logic [3:0]        item_pos_q, item_pos_d;
    logic              en_q, en_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef PARAM_SCHED_TIMEOUT_EN
    logic [TO_W-1:0]   to_q, to_d;
    logic [TO_W-1:0]   to_inc;
    logic              err_q, err_d;

    assign to_inc = to_q + 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        item_idx_d  = item_idx_q;
        item_addr_d = item_addr_q;
        item_pos_d  = item_pos_q;
`ifdef PARAM_SCHED_TIMEOUT_EN
        to_d        = to_q;
        err_d       = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (ps_if.start) begin
                    if (ps_if.count != '0) begin
                        base_d  = ps_if.base_addr;
                        count_d = ps_if.count;
                        idx_d   = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LAUNCH: begin
`ifdef PARAM_SCHED_TIMEOUT_EN
                to_d    = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ps_if.current_finish) begin
                    item_idx_d  = idx_q;
                    item_addr_d = base_q + idx_q;
                    item_pos_d  = ps_if.position;
                    state_d     = S_HAND;
                end
`ifdef PARAM_SCHED_TIMEOUT_EN
                // Expire on the WAIT cycle that would bring the count to all-ones.
                else if (to_inc == {TO_W{1'b1}}) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_inc;
                end
`endif
            end
            S_HAND: begin
                if (ps_if.item_ready) begin
                    if (idx_q == count_q - 1'b1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ps_if.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
`ifdef PARAM_SCHED_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end

        // Outputs are registered images of the next state.
        en_d    = (state_d == S_LAUNCH) || (state_d == S_WAIT);
        valid_d = (state_d == S_HAND);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            item_idx_q  <= '0;
            item_addr_q <= '0;
            item_pos_q  <= '0;
            en_q        <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PARAM_SCHED_TIMEOUT_EN
            to_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            item_idx_q  <= item_idx_d;
            item_addr_q <= item_addr_d;
            item_pos_q  <= item_pos_d;
            en_q        <= en_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PARAM_SCHED_TIMEOUT_EN
            to_q        <= to_d;
            err_q       <= err_d;
`endif
        end
    end

    assign ps_if.en_get_param = en_q;
    assign ps_if.item_valid   = valid_q;
    assign ps_if.item_idx     = item_idx_q;
    assign ps_if.item_addr    = item_addr_q;
    assign ps_if.item_pos     = item_pos_q;
    assign ps_if.busy         = busy_q;
    assign ps_if.done         = done_q;
`ifdef PARAM_SCHED_TIMEOUT_EN
    assign ps_if.err          = err_q;
`else
    assign ps_if.err          = 1'b0;
`endif

endmodule

// File: tb/tb_param_sched.sv
// -----------------------------------------------------------------------------
// tb_param_sched
// Self-checking bench for param_sched. Each run is described at transaction
// level (base, count, finish latency, ready stall, optional abort point) and
// expected outputs follow from the documented cycle timing and from
// item_addr = (base + idx) mod 4096.
// -----------------------------------------------------------------------------
module tb_param_sched;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    param_sched_if #(.ADDR_W(AW)) bus_if ();

    param_sched #(.ADDR_W(AW), .TO_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .ps_if (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input bit en, input bit vld, input bit bsy, input bit dn);
        check_val({tag, ".en"},   bus_if.en_get_param, en);
        check_val({tag, ".vld"},  bus_if.item_valid,   vld);
        check_val({tag, ".busy"}, bus_if.busy,         bsy);
        check_val({tag, ".done"}, bus_if.done,         dn);
        check_val({tag, ".err"},  bus_if.err,          1'b0);
    endtask

    task automatic check_item(input string tag, input int idx, input int addr, input int pos);
        check_val({tag, ".idx"},  bus_if.item_idx,  idx);
        check_val({tag, ".addr"}, bus_if.item_addr, addr);
        check_val({tag, ".pos"},  bus_if.item_pos,  pos);
    endtask

    // lat: WAIT cycles before finish (0 = random 1..4)
    // rdy: HAND stall cycles before ready (-1 = random 0..3)
    // abort_set: set index whose WAIT gets aborted (-1 = none)
    task automatic run(input int base, input int cnt, input int lat, input int rdy,
                       input int abort_set, input bit pos_seq);
        int l, r, exp_addr, pos;
        bus_if.base_addr = base[AW-1:0];
        bus_if.count     = cnt[AW-1:0];
        bus_if.start     = 1'b1;
        tick();
        bus_if.start     = 1'b0;
        // Scramble range inputs: the run must use the latched values.
        bus_if.base_addr = AW'($urandom);
        bus_if.count     = AW'($urandom);
        if (cnt == 0) begin
            check_ctl("zero", 1'b0, 1'b0, 1'b1, 1'b1);
            tick();
            check_ctl("zero_end", 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            check_ctl("launch", 1'b1, 1'b0, 1'b1, 1'b0);
            l = (lat > 0) ? lat : int'($urandom_range(1, 4));
            r = (rdy >= 0) ? rdy : int'($urandom_range(0, 3));
            // A finish seen during LAUNCH is stale and must be ignored.
            bus_if.current_finish = 1'($urandom);
            tick();
            bus_if.current_finish = 1'b0;
            check_ctl("wait", 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == abort_set) begin
                bus_if.abort = 1'b1;
                tick();
                bus_if.abort = 1'b0;
                check_ctl("abort", 1'b0, 1'b0, 1'b0, 1'b0);
                repeat (3) begin
                    tick();
                    check_ctl("post_abort", 1'b0, 1'b0, 1'b0, 1'b0);
                end
                return;
            end
            for (int j = 1; j < l; j++) begin
                tick();
                check_ctl("wait_n", 1'b1, 1'b0, 1'b1, 1'b0);
            end
            pos = pos_seq ? (3 + 2 * i) : int'($urandom_range(0, 15));
            bus_if.position       = pos[3:0];
            bus_if.current_finish = 1'b1;
            tick();
            bus_if.current_finish = 1'b0;
            bus_if.position       = 4'($urandom);
            exp_addr = (base + i) % 4096;
            check_ctl("hand", 1'b0, 1'b1, 1'b1, 1'b0);
            check_item("hand", i, exp_addr, pos);
            repeat (r) begin
                bus_if.item_ready = 1'b0;
                bus_if.start      = 1'($urandom);
                tick();
                bus_if.start      = 1'b0;
                check_ctl("hold", 1'b0, 1'b1, 1'b1, 1'b0);
                check_item("hold", i, exp_addr, pos);
            end
            bus_if.item_ready = 1'b1;
            tick();
            bus_if.item_ready = 1'b0;
            if (i == cnt - 1) begin
                check_ctl("done", 1'b0, 1'b0, 1'b1, 1'b1);
                tick();
                check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        int base, cnt, ab;
        bus_if.start          = 1'b0;
        bus_if.abort          = 1'b0;
        bus_if.base_addr      = '0;
        bus_if.count          = '0;
        bus_if.current_finish = 1'b0;
        bus_if.position       = '0;
        bus_if.item_ready     = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_item("reset", 0, 0, 0);
        bus_if.current_finish = 1'b1;
        bus_if.item_ready     = 1'b1;
        bus_if.position       = 4'hA;
        tick();
        tick();
        bus_if.current_finish = 1'b0;
        bus_if.item_ready     = 1'b0;
        check_ctl("idle_fin", 1'b0, 1'b0, 1'b0, 1'b0);
        check_item("idle_fin", 0, 0, 0);

        run(10, 3, 2, 0, -1, 1'b1);
        tick();
        run(100, 2, 1, 5, -1, 1'b0);
        tick();
        run(55, 0, 1, 0, -1, 1'b0);
        tick();
        run(4094, 3, 1, 0, -1, 1'b0);
        tick();
        run(200, 4, 2, 0, 1, 1'b0);
        tick();
        run(4095, 2, 1, 1, -1, 1'b0);
        tick();

        for (int k = 0; k < 30; k++) begin
            base = int'($urandom_range(0, 4095));
            cnt  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
            ab   = (cnt > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
            run(base, cnt, 0, -1, ab, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

`ifdef PARAM_SCHED_TIMEOUT_EN
        bus_if.base_addr = 12'd7;
        bus_if.count     = 12'd2;
        bus_if.start     = 1'b1;
        tick();
        bus_if.start     = 1'b0;
        repeat (255) tick();
        check_val("to.wait_en", bus_if.en_get_param, 1'b1);
        check_val("to.wait_done", bus_if.done, 1'b0);
        tick();
        check_val("to.done", bus_if.done, 1'b1);
        check_val("to.err", bus_if.err, 1'b1);
        check_val("to.en", bus_if.en_get_param, 1'b0);
        tick();
        check_val("to.idle", bus_if.busy, 1'b0);
        check_val("to.err_clr", bus_if.err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/param_sched.md
# param_sched

Sequencer for the parameter-fetch stage. It walks a contiguous range of parameter-set addresses, enables `get_param` once per set, and waits for that set's `current_finish`. It then holds each captured result (index, address, position) on a valid/ready handshake until the downstream engine accepts it. It sits between the top-level control FSM (start/abort/done) and `get_param`, and is the only driver of `en_get_param`.

## Interface
Parameters:
- `ADDR_W`, 12: width of parameter-set addresses and counts.
- `TO_W`, 8: width of the watchdog counter. Used only when `PARAM_SCHED_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: launch a run. Sampled only in IDLE.
- `abort`  in  1: synchronous abort of the current run.
- `base_addr`  in  ADDR_W: first parameter-set address. Latched on `start`.
- `count`  in  ADDR_W: number of sets to fetch. Latched on `start`.
- `en_get_param`  out  1: enable to `get_param`.
- `current_finish`  in  1: `get_param` has finished the current set.
- `position`  in  4: `get_param` execution position. Captured on finish.
- `item_valid`  out  1: result available to downstream.
- `item_ready`  in  1: downstream accepts the result.
- `item_idx`  out  ADDR_W: 0-based index of the set within the run.
- `item_addr`  out  ADDR_W: `base_addr + item_idx`, modulo 2^ADDR_W.
- `item_pos`  out  4: captured `position`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of a run.
- `err`  out  1: one-cycle pulse, coincident with `done`, on watchdog expiry.

## Operation
- States: IDLE, LAUNCH, WAIT, HAND, DONE. All outputs are registered.
- Reset values: state = IDLE; all outputs = 0; internal counters = 0.
- IDLE:
  - `start`=1 with `count`≠0: latch `base_addr` and `count`, set idx=0, go to LAUNCH.
  - `start`=1 with `count`=0: go to DONE; no `en_get_param`.
- LAUNCH: `en_get_param`=1; go to WAIT. `current_finish` is ignored in this state because it may be stale from the previous set.
- WAIT:
  - `en_get_param` stays 1.
  - On `current_finish`=1: capture `position` into `item_pos`, drive `en_get_param`=0 and `item_valid`=1 from the next cycle, go to HAND.
- HAND: `item_valid`=1. `item_idx`, `item_addr` and `item_pos` hold stable until `item_ready`=1. On the handshake:
  - if idx = count−1: go to DONE;
  - otherwise: idx+1, go to LAUNCH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `abort`=1 in any non-IDLE state: next cycle is IDLE with `en_get_param`, `item_valid`, `busy` = 0. No `done` pulse. `abort` has priority over every other transition.
- `start` outside IDLE is ignored.
- `item_addr` wraps: `base_addr`=4095, idx=1 gives 0.
- `count`=4095 is legal. idx never exceeds count−1.

## Timing
- `start` sampled at edge t → `busy`=1 and `en_get_param`=1 from t+1.
- `current_finish` sampled at edge f → `en_get_param`=0 and `item_valid`=1 from f+1.
- Handshake at edge h:
  - next set: `en_get_param`=1 from h+1;
  - last set: `done`=1 during h+1 only, `busy`=0 from h+2.
- Minimum cost per set is 3 cycles (LAUNCH, WAIT, HAND), given `current_finish` and `item_ready` tied high.
- `rst` has priority over `abort`; it takes effect at the next edge regardless of state.

## Configuration
- `PARAM_SCHED_TIMEOUT_EN` defined:
  - a TO_W-bit counter clears on entry to WAIT and increments each WAIT cycle;
  - if it reaches 2^TO_W−1 with no `current_finish`, the block leaves WAIT, drops `en_get_param`, and goes to DONE with `err`=1 alongside `done`;
  - remaining sets are skipped.
- Not defined: no counter; WAIT waits indefinitely; `err` is tied to 0.

## Test plan
- Reset, then idle: all outputs 0, `busy`=0; `current_finish` pulses cause no change.
- `base_addr`=10, `count`=3, finish 2 cycles after each enable, `item_ready`=1:
  - items (0,10), (1,11), (2,12) in order;
  - `position` values 3, 5, 7 are captured into `item_pos`;
  - exactly one `done` pulse.
- `item_ready` held low for 5 cycles in HAND: outputs stable, `en_get_param` stays 0, no extra launch; release → next set launches the cycle after the handshake.
- `count`=0: `done` the cycle after `start`; `en_get_param` never rises.
- `base_addr`=4094, `count`=3: `item_addr` sequence 4094, 4095, 0.
- `abort` in WAIT during set 1 of 4: IDLE the next cycle, no `done`, no `item_valid`. With `PARAM_SCHED_TIMEOUT_EN` and `current_finish` never asserted: `done`=`err`=1 after 255 WAIT cycles.
